// File: rtl/fft_bitrev_reorder.sv
// Output-reorder stage for the radix-2^2 SDF FFT pipeline.
// The FFT delivers each frame in bit-reversed bin order. This block writes
// every sample to its natural-order address in one bank of a ping-pong buffer,
// then streams the finished bank back out as X[0]..X[N-1]. While one bank is
// read, the other bank fills, so back-to-back frames stream without gaps.
module fft_bitrev_reorder #(
  parameter int LOG_N = 6,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in_en,
  input  logic [WIDTH-1:0] data_in_re,
  input  logic [WIDTH-1:0] data_in_im,
  output logic             data_out_en,
  output logic [WIDTH-1:0] data_out_re,
  output logic [WIDTH-1:0] data_out_im,
  output logic             frame_abort
);

  localparam int N = 1 << LOG_N;
  localparam logic [LOG_N-1:0] LAST = '1;

  typedef enum logic {
    IDLE,
    READ
  } state_t;

  // Ping-pong storage: bank index first, then natural-order bin address.
  // Each word packs {re, im}.
  logic [2*WIDTH-1:0] mem [2][N];

  logic [LOG_N-1:0] wrCnt_q, wrCnt_d;
  logic             wrBank_q, wrBank_d;
  logic             abort_q, abort_d;
  logic             setFull;

  logic [1:0]       full_q, full_d;
  logic             clrFull;

  state_t           state_q, state_d;
  logic [LOG_N-1:0] rdCnt_q, rdCnt_d;
  logic             rdBank_q, rdBank_d;
  logic             outEn_q, outEn_d;
  logic [WIDTH-1:0] outRe_q, outRe_d;
  logic [WIDTH-1:0] outIm_q, outIm_d;

  // Reverse all LOG_N bits of an arrival index to get its natural bin number.
  function automatic logic [LOG_N-1:0] bitRev(input logic [LOG_N-1:0] x);
    logic [LOG_N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG_N; i++) begin
      r[i] = x[LOG_N-1-i];
    end
    return r;
  endfunction

  // Write side: count arriving samples, close a bank when a frame completes,
  // and drop the frame if the input enable falls before all N samples arrived.
  always_comb begin
    wrCnt_d  = wrCnt_q;
    wrBank_d = wrBank_q;
    abort_d  = 1'b0;
    setFull  = 1'b0;
    if (data_in_en) begin
      wrCnt_d = wrCnt_q + 1'b1;
      if (wrCnt_q == LAST) begin
        setFull  = 1'b1;
        wrBank_d = ~wrBank_q;
      end
    end else if (wrCnt_q != '0) begin
      wrCnt_d = '0;
      abort_d = 1'b1;
    end
  end

  // Storage array is not reset; stale contents are never read because a bank
  // is only read after a complete frame has been written into it.
  always_ff @(posedge clk) begin
    if (data_in_en) begin
      mem[wrBank_q][bitRev(wrCnt_q)] <= {data_in_re, data_in_im};
    end
  end

  // Read FSM: wait for the current read bank to fill, then stream it in
  // natural order, chaining directly into the other bank if it is ready.
  always_comb begin
    state_d  = state_q;
    rdCnt_d  = rdCnt_q;
    rdBank_d = rdBank_q;
    clrFull  = 1'b0;
    outEn_d  = 1'b0;
    outRe_d  = '0;
    outIm_d  = '0;
    case (state_q)
      IDLE: begin
        if (full_q[rdBank_q]) begin
          state_d = READ;
          rdCnt_d = '0;
        end
      end
      READ: begin
        outEn_d            = 1'b1;
        {outRe_d, outIm_d} = mem[rdBank_q][rdCnt_q];
        rdCnt_d            = rdCnt_q + 1'b1;
        if (rdCnt_q == LAST) begin
          clrFull  = 1'b1;
          rdBank_d = ~rdBank_q;
          if (!full_q[~rdBank_q]) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bank-full flags: writer sets a flag when it closes a bank, reader clears
  // it once the last entry has been read out.
  always_comb begin
    full_d = full_q;
    if (clrFull) begin
      full_d[rdBank_q] = 1'b0;
    end
    if (setFull) begin
      full_d[wrBank_q] = 1'b1;
    end
  end

  // State and output registers; reset discards any partial or unread frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrCnt_q  <= '0;
      wrBank_q <= 1'b0;
      abort_q  <= 1'b0;
      full_q   <= '0;
      state_q  <= IDLE;
      rdCnt_q  <= '0;
      rdBank_q <= 1'b0;
      outEn_q  <= 1'b0;
      outRe_q  <= '0;
      outIm_q  <= '0;
    end else begin
      wrCnt_q  <= wrCnt_d;
      wrBank_q <= wrBank_d;
      abort_q  <= abort_d;
      full_q   <= full_d;
      state_q  <= state_d;
      rdCnt_q  <= rdCnt_d;
      rdBank_q <= rdBank_d;
      outEn_q  <= outEn_d;
      outRe_q  <= outRe_d;
      outIm_q  <= outIm_d;
    end
  end

  assign data_out_en = outEn_q;
  assign data_out_re = outRe_q;
  assign data_out_im = outIm_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for fft_bitrev_reorder (N=64, WIDTH=32).
// Stimulus pushes each complete frame's natural-order samples into a queue;
// a negedge monitor pops and compares whenever data_out_en is high.
module tb_fft_bitrev_reorder;

  localparam int LOG_N = 6;
  localparam int WIDTH = 32;
  localparam int N     = 64;

  logic             clk;
  logic             reset;
  logic             dataInEn;
  logic [WIDTH-1:0] dataInRe;
  logic [WIDTH-1:0] dataInIm;
  logic             dataOutEn;
  logic [WIDTH-1:0] dataOutRe;
  logic [WIDTH-1:0] dataOutIm;
  logic             frameAbort;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [63:0] expQ[$];

  int  frameStartCyc = 0;
  int  burstStartCyc = 0;
  int  burstCount = 0;
  int  lastBurstLen = 0;
  int  lowRun = 0;
  int  gapBeforeBurst = 0;
  int  abortCount = 0;
  bit  inBurst = 0;

  fft_bitrev_reorder #(
    .LOG_N(LOG_N),
    .WIDTH(WIDTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in_en (dataInEn),
    .data_in_re (dataInRe),
    .data_in_im (dataInIm),
    .data_out_en(dataOutEn),
    .data_out_re(dataOutRe),
    .data_out_im(dataOutIm),
    .frame_abort(frameAbort)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter: after edge m has settled, cyc == m.
  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  function automatic logic [5:0] bitRev(input logic [5:0] x);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) begin
      r[i] = x[5-i];
    end
    return r;
  endfunction

  // Packed {re, im} that natural bin 'bin' of a frame should carry.
  function automatic logic [63:0] sampleVal(input int mode, input int off, input int bin);
    logic [31:0] re;
    logic [31:0] im;
    int v;
    if (mode == 0) begin
      v  = off + bin;
      re = 32'(v);
      im = 32'(-v);
    end else begin
      re = bin[0] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      im = ~re;
    end
    return {re, im};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive 'len' samples in bit-reversed order; only full frames expect output.
  task automatic applyStimulus(input int mode, input int off, input int len);
    logic [5:0] k6;
    if (len == N) begin
      for (int j = 0; j < N; j++) begin
        expQ.push_back(sampleVal(mode, off, j));
      end
    end
    for (int k = 0; k < len; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) frameStartCyc = cyc + 1;
      k6 = 6'(k);
      dataInEn = 1'b1;
      {dataInRe, dataInIm} = sampleVal(mode, off, int'(bitRev(k6)));
    end
  endtask

  task automatic applyIdle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      dataInEn = 1'b0;
      dataInRe = '0;
      dataInIm = '0;
    end
  endtask

  // Wait (bounded) until every expected sample has been seen and output is idle.
  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      #1;
      if (expQ.size() == 0 && !inBurst) begin
        done = 1;
        break;
      end
    end
    checkOutput("drain_done", 64'(done), 64'd1);
    expQ.delete();
  endtask

  // Monitor: compare output samples against the scoreboard, track bursts,
  // gaps and abort pulses.
  always @(negedge clk) begin
    if (dataOutEn) begin
      if (!inBurst) begin
        inBurst        = 1;
        burstStartCyc  = cyc;
        gapBeforeBurst = lowRun;
        burstCount     = 0;
      end
      burstCount++;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: got 0x%0h, expected no output", {dataOutRe, dataOutIm});
      end else begin
        checkOutput("data_out", {dataOutRe, dataOutIm}, expQ.pop_front());
      end
    end else begin
      if (inBurst) begin
        inBurst      = 0;
        lastBurstLen = burstCount;
        lowRun       = 0;
      end
      lowRun++;
      checkOutput("idle_data_zero", {dataOutRe, dataOutIm}, 64'd0);
    end
    if (frameAbort) abortCount++;
  end

  initial begin
    int abortBefore;
    bit reached;

    reset    = 1'b1;
    dataInEn = 1'b0;
    dataInRe = '0;
    dataInIm = '0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_en", 64'(dataOutEn), 64'd0);
    checkOutput("reset_data", {dataOutRe, dataOutIm}, 64'd0);
    checkOutput("reset_abort", 64'(frameAbort), 64'd0);
    reset = 1'b0;
    applyIdle(2);

    $display("[TB] single frame");
    applyStimulus(0, 0, N);
    applyIdle(1);
    drain();
    checkOutput("latency_first_out", 64'(burstStartCyc), 64'(frameStartCyc + N + 1));
    checkOutput("single_burst_len", 64'(lastBurstLen), 64'd64);

    $display("[TB] three back-to-back frames");
    applyStimulus(0, 0, N);
    applyStimulus(0, 1000, N);
    applyStimulus(0, 2000, N);
    applyIdle(1);
    drain();
    checkOutput("b2b_burst_len", 64'(lastBurstLen), 64'd192);

    $display("[TB] short frame then full frame");
    abortBefore = abortCount;
    applyStimulus(0, 500, 20);
    applyIdle(5);
    checkOutput("abort_pulses", 64'(abortCount - abortBefore), 64'd1);
    applyStimulus(0, 300, N);
    applyIdle(1);
    drain();
    checkOutput("after_abort_burst_len", 64'(lastBurstLen), 64'd64);

    $display("[TB] async reset mid-output");
    applyStimulus(0, 700, N);
    applyIdle(1);
    reached = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #2;
      if (burstCount >= 30 && inBurst) begin
        reached = 1;
        break;
      end
    end
    checkOutput("reset_wait", 64'(reached), 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("async_reset_en", 64'(dataOutEn), 64'd0);
    checkOutput("async_reset_data", {dataOutRe, dataOutIm}, 64'd0);
    expQ.delete();
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    applyIdle(2);
    applyStimulus(0, 4000, N);
    applyIdle(1);
    drain();
    checkOutput("post_reset_burst_len", 64'(lastBurstLen), 64'd64);

    $display("[TB] two frames with 10 idle cycles between");
    applyStimulus(0, 100, N);
    applyIdle(10);
    applyStimulus(0, 200, N);
    applyIdle(1);
    drain();
    checkOutput("gap_len", 64'(gapBeforeBurst), 64'd10);
    checkOutput("gap_burst_len", 64'(lastBurstLen), 64'd64);

    $display("[TB] extreme values");
    applyStimulus(1, 0, N);
    applyIdle(1);
    drain();

    checkOutput("total_aborts", 64'(abortCount), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
